// File: rtl/imm_decode_stage.sv
// Decode-stage immediate generator for the RV core.
// The immediate and its format are decoded from the incoming instruction word,
// then registered behind a valid/ready handshake. One output register plus a
// single skid entry give full throughput under backpressure. The skid entry is
// only filled when the output register is stalled, and in_ready comes straight
// from a flop, so it never depends combinationally on out_ready.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;
  localparam logic [2:0] FMT_ILL  = 3'd7;

  // Returns {fmt, imm}. Each raw immediate field is gathered into a signed
  // variable of its natural width. The XLEN-wide cast then does the sign
  // extension, so the same code serves XLEN=32 and XLEN=64.
  function automatic logic [XLEN+2:0] decode_inst(input logic [31:0] inst);
    logic signed [11:0] i12;
    logic signed [11:0] s12;
    logic signed [12:0] b13;
    logic signed [31:0] u32;
    logic signed [20:0] j21;
    logic [XLEN-1:0]    imm;
    logic [2:0]         fmt;
    i12 = inst[31:20];
    s12 = {inst[31:25], inst[11:7]};
    b13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    u32 = {inst[31:12], 12'b0};
    j21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    imm = '0;
    fmt = FMT_ILL;
    if (inst[1:0] == 2'b11) begin
      case (inst[6:2])
        5'b00000, 5'b00011, 5'b00100, 5'b11001: begin
          fmt = FMT_I;
          imm = XLEN'(i12);
        end
        5'b00110: begin
          // op-imm-32 only exists on RV64
          if (XLEN == 64) begin
            fmt = FMT_I;
            imm = XLEN'(i12);
          end
        end
        5'b01000: begin
          fmt = FMT_S;
          imm = XLEN'(s12);
        end
        5'b11000: begin
          fmt = FMT_B;
          imm = XLEN'(b13);
        end
        5'b01101, 5'b00101: begin
          fmt = FMT_U;
          imm = XLEN'(u32);
        end
        5'b11011: begin
          fmt = FMT_J;
          imm = XLEN'(j21);
        end
        5'b11100: begin
          if (inst[14]) begin
            fmt = FMT_Z;
            imm = XLEN'(inst[19:15]);
          end else begin
            fmt = FMT_I;
            imm = XLEN'(i12);
          end
        end
        5'b01100, 5'b01110: begin
          fmt = FMT_NONE;
        end
        default: begin
          fmt = FMT_ILL;
        end
      endcase
    end
    return {fmt, imm};
  endfunction

  // Stage p0: combinational decode of the incoming word.
  logic [XLEN+2:0] dec_p0;
  logic [XLEN-1:0] dec_imm_p0;
  logic [2:0]      dec_fmt_p0;
  logic            in_fire;
  logic            out_load;

  assign dec_p0                   = decode_inst(in_inst);
  assign {dec_fmt_p0, dec_imm_p0} = dec_p0;

  // Stage p1: skid entry that sits behind the output register.
  logic             skid_vld_p1;
  logic [XLEN-1:0]  skid_imm_p1;
  logic [2:0]       skid_fmt_p1;
  logic [TAG_W-1:0] skid_tag_p1;

  assign in_ready = ~skid_vld_p1;
  assign in_fire  = in_valid & in_ready;
  // The output register may take new data when it is empty or is being consumed.
  assign out_load = ~out_valid | out_ready;

  // Occupancy control: the skid entry fills only while the output is stalled
  // and empties whenever the output register is free to take it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else begin
      if (out_load) begin
        out_valid   <= skid_vld_p1 | in_fire;
        skid_vld_p1 <= 1'b0;
      end else if (in_fire) begin
        skid_vld_p1 <= 1'b1;
      end
    end
  end

  // Output register: the older skid entry has priority over the new input, which keeps FIFO order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_imm <= '0;
      out_fmt <= FMT_NONE;
      out_tag <= '0;
    end else if (out_load && skid_vld_p1) begin
      out_imm <= skid_imm_p1;
      out_fmt <= skid_fmt_p1;
      out_tag <= skid_tag_p1;
    end else if (out_load && in_fire) begin
      out_imm <= dec_imm_p0;
      out_fmt <= dec_fmt_p0;
      out_tag <= in_tag;
    end
  end

  // Skid payload: captures the decoded input only when the output register is stalled.
  always_ff @(posedge clk) begin
    if (!out_load && in_fire) begin
      skid_imm_p1 <= dec_imm_p0;
      skid_fmt_p1 <= dec_fmt_p0;
      skid_tag_p1 <= in_tag;
    end
  end

endmodule
